// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared definitions for the core memory arbiter.
//            - memcontrol encodings as driven by the attached cores
//            - arbiter FSM state encoding
//            - small helper to classify a memcontrol code
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Core memcontrol encoding. These values must match the core's own encoding.
  localparam logic [1:0] MC_IDLE    = 2'b00;
  localparam logic [1:0] MC_READ    = 2'b01;
  localparam logic [1:0] MC_WRITE   = 2'b10;
  localparam logic [1:0] MC_ILLEGAL = 2'b11;

  // Arbiter FSM states. Values are fixed so waveforms read the same on
  // every tool.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // True for the two codes that request a RAM access.
  function automatic logic mc_is_access(input logic [1:0] mc);
    return (mc == MC_READ) || (mc == MC_WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Scans the request vector
//            starting at index ptr, ascending with wrap-around, and returns
//            the first requester found.
// Ports    :
//   req      in   N_CORES   request vector (one bit per core)
//   ptr      in   PTR_W     index where the search starts (< N_CORES)
//   gnt_idx  out  PTR_W     index of the selected requester
//   any      out  1         at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N_CORES = 4,
  localparam int PTR_W   = $clog2(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               any
);

  // One extra bit is enough to hold ptr + offset before the modulo, since
  // both are below N_CORES <= 2**PTR_W.
  always_comb begin
    logic [PTR_W:0] sum;
    logic [PTR_W:0] idx;
    logic           found;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N_CORES; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      idx = (sum >= (PTR_W+1)'(N_CORES)) ? sum - (PTR_W+1)'(N_CORES) : sum;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx[PTR_W-1:0];
      end
    end
    any = found;
  end

endmodule
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter
// Purpose  : Shares one single-port synchronous data RAM between N_CORES
//            cores. Each core has a one-entry request slot; pending slots are
//            served round-robin, one access at a time, and completion is
//            signalled with a one-cycle ready pulse per core.
// Ports    :
//   Clock            in   1               rising-edge clock
//   Reset            in   1               synchronous, active-high
//   core_memcontrol  in   2*N_CORES       per core: 00 idle 01 read 10 write 11 illegal
//   core_addr        in   ADDR_W*N_CORES  per-core address
//   core_wdata       in   DATA_W*N_CORES  per-core write data
//   core_rdata       out  DATA_W*N_CORES  per-core read data, held until next read
//   core_ready       out  N_CORES         1-cycle pulse: access for core k done
//   core_busy        out  N_CORES         core k has a captured, uncompleted request
//   mem_en           out  1               RAM access strobe
//   mem_we           out  1               1 = write, 0 = read
//   mem_addr         out  ADDR_W          RAM address (0 outside an access)
//   mem_wdata        out  DATA_W          RAM write data (0 outside an access)
//   mem_rdata        in   DATA_W          RAM read data, RD_LAT cycles after mem_en
//   err_illegal      out  1               sticky: a core presented code 11
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [2*N_CORES-1:0]      core_memcontrol,
  input  logic [ADDR_W*N_CORES-1:0] core_addr,
  input  logic [DATA_W*N_CORES-1:0] core_wdata,
  output logic [DATA_W*N_CORES-1:0] core_rdata,
  output logic [N_CORES-1:0]        core_ready,
  output logic [N_CORES-1:0]        core_busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      err_illegal
);

  localparam int PTR_W  = $clog2(N_CORES);
  localparam int WAIT_W = $clog2(RD_LAT + 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_t         state;
  logic [PTR_W-1:0]   grant;     // core being served, latched in IDLE
  logic [PTR_W-1:0]   rr_ptr;    // where the next round-robin search starts
  logic [WAIT_W-1:0]  wait_cnt;  // remaining WAIT cycles

  logic [N_CORES-1:0] slot_valid;
  logic [N_CORES-1:0] slot_we;
  logic [ADDR_W-1:0]  slot_addr  [N_CORES];
  logic [DATA_W-1:0]  slot_wdata [N_CORES];
  logic [N_CORES-1:0] armed;     // core has been idle since its last capture
  logic [DATA_W-1:0]  rdata_q    [N_CORES];

  // --------------------------------------------------------------------------
  // Per-core decode
  // --------------------------------------------------------------------------
  logic [1:0]         mc        [N_CORES];
  logic [ADDR_W-1:0]  req_addr  [N_CORES];
  logic [DATA_W-1:0]  req_wdata [N_CORES];
  logic [N_CORES-1:0] capture;
  logic [N_CORES-1:0] illegal;

  for (genvar k = 0; k < N_CORES; k++) begin : g_core
    assign mc[k]        = core_memcontrol[2*k +: 2];
    assign req_addr[k]  = core_addr[ADDR_W*k +: ADDR_W];
    assign req_wdata[k] = core_wdata[DATA_W*k +: DATA_W];

    // armed blocks a request that is still held after its ready pulse from
    // being captured a second time.
    assign capture[k] = mc_is_access(mc[k]) && !slot_valid[k] && armed[k];
    assign illegal[k] = (mc[k] == MC_ILLEGAL);

    assign core_rdata[DATA_W*k +: DATA_W] = rdata_q[k];
    assign core_ready[k] = (state == DONE) && (grant == PTR_W'(k));
  end

  assign core_busy = slot_valid;

  // --------------------------------------------------------------------------
  // Round-robin selection among the pending slots
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .N_CORES (N_CORES)
  ) u_rr_arbiter (
    .req     (slot_valid),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // --------------------------------------------------------------------------
  // Request slots, armed bits and the sticky illegal-code flag.
  // A slot is cleared on the same edge as its ready pulse ends; it cannot be
  // captured on that edge because armed is still 0 while the slot is valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      slot_valid  <= '0;
      slot_we     <= '0;
      armed       <= '1;
      err_illegal <= 1'b0;
      for (int k = 0; k < N_CORES; k++) begin
        slot_addr[k]  <= '0;
        slot_wdata[k] <= '0;
      end
    end else begin
      err_illegal <= err_illegal | (|illegal);
      for (int k = 0; k < N_CORES; k++) begin
        if (mc[k] == MC_IDLE) begin
          armed[k] <= 1'b1;
        end else if (capture[k]) begin
          armed[k] <= 1'b0;
        end

        if (core_ready[k]) begin
          slot_valid[k] <= 1'b0;
        end else if (capture[k]) begin
          slot_valid[k] <= 1'b1;
          slot_we[k]    <= (mc[k] == MC_WRITE);
          slot_addr[k]  <= req_addr[k];
          slot_wdata[k] <= req_wdata[k];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Access sequencer: IDLE -> ACCESS -> (WAIT x RD_LAT for reads) -> DONE
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] next_ptr;
  assign next_ptr = (grant == PTR_W'(N_CORES - 1)) ? '0 : grant + PTR_W'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      wait_cnt <= '0;
      for (int k = 0; k < N_CORES; k++) begin
        rdata_q[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant <= arb_idx;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (slot_we[grant]) begin
            state <= DONE;
          end else begin
            wait_cnt <= WAIT_W'(RD_LAT);
            state    <= WAIT;
          end
        end
        WAIT: begin
          // RAM data is valid in the last WAIT cycle; capture it on its edge.
          if (wait_cnt == WAIT_W'(1)) begin
            rdata_q[grant] <= mem_rdata;
            state          <= DONE;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        DONE: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RAM port: decoded from state and the latched grant only, so it is free of
  // any combinational path from the core inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_en    = (state == ACCESS);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ACCESS) begin
      mem_we    = slot_we[grant];
      mem_addr  = slot_addr[grant];
      mem_wdata = slot_wdata[grant];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mem_arbiter
// Purpose  : Self-checking bench for core_mem_arbiter (4 cores, 16-bit
//            address/data, RD_LAT=1). Expected RAM accesses and ready pulses
//            are queued when stimulus is driven and compared as the DUT
//            produces them; latencies are checked against a cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

  localparam logic [1:0] MC_IDLE    = 2'b00;
  localparam logic [1:0] MC_READ    = 2'b01;
  localparam logic [1:0] MC_WRITE   = 2'b10;
  localparam logic [1:0] MC_ILLEGAL = 2'b11;

  logic        Clock;
  logic        Reset;
  logic [7:0]  core_memcontrol;
  logic [63:0] core_addr;
  logic [63:0] core_wdata;
  logic [63:0] core_rdata;
  logic [3:0]  core_ready;
  logic [3:0]  core_busy;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        err_illegal;

  core_mem_arbiter #(
    .N_CORES (4),
    .ADDR_W  (16),
    .DATA_W  (16),
    .RD_LAT  (1)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .core_memcontrol (core_memcontrol),
    .core_addr       (core_addr),
    .core_wdata      (core_wdata),
    .core_rdata      (core_rdata),
    .core_ready      (core_ready),
    .core_busy       (core_busy),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .err_illegal     (err_illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM model, 1-cycle read latency. Unwritten locations read back a
  // recognisable pattern derived from the address.
  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {8'hC0, a};
  endfunction

  logic [15:0] ram [256];
  bit   [255:0] ram_wr;

  always @(posedge Clock) begin
    if (mem_en && mem_we) begin
      ram[mem_addr[7:0]]    <= mem_wdata;
      ram_wr[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      mem_rdata <= ram_wr[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    end
  end

  // Scoreboard
  typedef struct packed { logic we; logic [15:0] addr; logic [15:0] wdata; } acc_t;
  typedef struct packed { logic [1:0] core; logic rd; logic [15:0] data; } rdy_t;
  acc_t acc_q[$];
  rdy_t rdy_q[$];
  acc_t a_pop;
  rdy_t r_pop;

  task automatic push_acc(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    acc_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    acc_q.push_back(t);
  endtask

  task automatic push_rdy(input logic [1:0] core, input logic rd, input logic [15:0] data);
    rdy_t t;
    t.core = core; t.rd = rd; t.data = data;
    rdy_q.push_back(t);
  endtask

  always @(negedge Clock) begin
    if (!Reset) begin
      if (mem_en) begin
        chk("acc_expected", 64'(acc_q.size() != 0), 64'd1);
        if (acc_q.size() != 0) begin
          a_pop = acc_q.pop_front();
          chk("acc_we", 64'(mem_we), 64'(a_pop.we));
          chk("acc_addr", 64'(mem_addr), 64'(a_pop.addr));
          if (a_pop.we) chk("acc_wdata", 64'(mem_wdata), 64'(a_pop.wdata));
        end
      end
      if (core_ready != 4'b0000) begin
        chk("rdy_expected", 64'(rdy_q.size() != 0), 64'd1);
        if (rdy_q.size() != 0) begin
          r_pop = rdy_q.pop_front();
          chk("rdy_vec", 64'(core_ready), 64'(4'b0001 << r_pop.core));
          if (r_pop.rd) chk("rdy_rdata", 64'(core_rdata[32'(r_pop.core)*16 +: 16]), 64'(r_pop.data));
        end
      end
    end
  end

  task automatic req(input int k, input logic [1:0] mc, input logic [15:0] a, input logic [15:0] d);
    core_memcontrol[2*k +: 2] = mc;
    core_addr[16*k +: 16]     = a;
    core_wdata[16*k +: 16]    = d;
  endtask

  // Polls for core k's ready pulse (bounded) and checks its cycle latency.
  task automatic wait_ready(input int k, input int t0, input int exp_lat, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!core_ready[k] && n < 40);
    chk({tag, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
  endtask

  int t0;
  int extra;

  initial begin
    Reset           = 1'b1;
    core_memcontrol = '0;
    core_addr       = '0;
    core_wdata      = '0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;

    // Reset state
    @(negedge Clock);
    chk("rst_mem_en",   64'(mem_en),      64'd0);
    chk("rst_mem_we",   64'(mem_we),      64'd0);
    chk("rst_mem_addr", 64'(mem_addr),    64'd0);
    chk("rst_mem_wdat", 64'(mem_wdata),   64'd0);
    chk("rst_ready",    64'(core_ready),  64'd0);
    chk("rst_busy",     64'(core_busy),   64'd0);
    chk("rst_rdata",    core_rdata,       64'd0);
    chk("rst_err",      64'(err_illegal), 64'd0);

    // 1: core0 write then read back
    @(posedge Clock); #1;
    push_acc(1'b1, 16'h0010, 16'hBEEF);
    push_rdy(2'd0, 1'b0, 16'h0000);
    req(0, MC_WRITE, 16'h0010, 16'hBEEF);
    t0 = cyc;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("t1_c2_mem_en",   64'(mem_en),   64'd1);
    chk("t1_c2_mem_we",   64'(mem_we),   64'd1);
    chk("t1_c2_mem_addr", 64'(mem_addr), 64'h0010);
    wait_ready(0, t0, 3, "t1_wr");
    req(0, MC_IDLE, 16'h0000, 16'h0000);
    @(posedge Clock); #1;
    push_acc(1'b0, 16'h0010, 16'h0000);
    push_rdy(2'd0, 1'b1, 16'hBEEF);
    req(0, MC_READ, 16'h0010, 16'h0000);
    t0 = cyc;
    wait_ready(0, t0, 4, "t1_rd");
    req(0, MC_IDLE, 16'h0000, 16'h0000);

    // 2: all four cores read together from rr_ptr=0
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) push_acc(1'b0, 16'(32'h20 + k), 16'h0000);
    for (int k = 0; k < 4; k++) push_rdy(2'(k), 1'b1, init_val(8'(32'h20 + k)));
    for (int k = 0; k < 4; k++) req(k, MC_READ, 16'(32'h20 + k), 16'h0000);
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_ready(k, t0, 4 * (k + 1), $sformatf("t2_core%0d", k));
      req(k, MC_IDLE, 16'h0000, 16'h0000);
      @(negedge Clock);
      chk($sformatf("t2_busy_after_core%0d", k), 64'(core_busy), (64'hF << (k + 1)) & 64'hF);
    end

    // 3: core1 holds READ across its ready pulse
    @(posedge Clock); #1;
    push_acc(1'b0, 16'h0031, 16'h0000);
    push_rdy(2'd1, 1'b1, init_val(8'h31));
    req(1, MC_READ, 16'h0031, 16'h0000);
    t0 = cyc;
    wait_ready(1, t0, 4, "t3_first");
    extra = 0;
    repeat (8) begin
      @(negedge Clock);
      if (mem_en) extra++;
    end
    chk("t3_no_dup_access", 64'(extra), 64'd0);
    chk("t3_busy1_clear", 64'(core_busy[1]), 64'd0);
    req(1, MC_IDLE, 16'h0000, 16'h0000);
    @(posedge Clock); #1;
    push_acc(1'b0, 16'h0031, 16'h0000);
    push_rdy(2'd1, 1'b1, init_val(8'h31));
    req(1, MC_READ, 16'h0031, 16'h0000);
    t0 = cyc;
    wait_ready(1, t0, 4, "t3_second");
    req(1, MC_IDLE, 16'h0000, 16'h0000);

    // 4: core2 presents the illegal code while core0 writes
    @(posedge Clock); #1;
    push_acc(1'b1, 16'h0040, 16'h1234);
    push_rdy(2'd0, 1'b0, 16'h0000);
    req(2, MC_ILLEGAL, 16'h0044, 16'hFFFF);
    req(0, MC_WRITE, 16'h0040, 16'h1234);
    t0 = cyc;
    @(negedge Clock);
    chk("t4_err_before_edge", 64'(err_illegal), 64'd0);
    wait_ready(0, t0, 3, "t4_wr_core0");
    req(0, MC_IDLE, 16'h0000, 16'h0000);
    chk("t4_err_set", 64'(err_illegal), 64'd1);
    chk("t4_busy2_never", 64'(core_busy[2]), 64'd0);
    req(2, MC_IDLE, 16'h0000, 16'h0000);
    repeat (3) @(negedge Clock);
    chk("t4_err_sticky", 64'(err_illegal), 64'd1);
    @(posedge Clock); #1;
    push_acc(1'b0, 16'h0040, 16'h0000);
    push_rdy(2'd2, 1'b1, 16'h1234);
    req(2, MC_READ, 16'h0040, 16'h0000);
    t0 = cyc;
    wait_ready(2, t0, 4, "t4_rd_core2");
    req(2, MC_IDLE, 16'h0000, 16'h0000);

    // 5: reset during core3's WAIT cycle
    @(posedge Clock); #1;
    push_acc(1'b0, 16'h0050, 16'h0000);
    req(3, MC_READ, 16'h0050, 16'h0000);
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    req(3, MC_IDLE, 16'h0000, 16'h0000);
    @(negedge Clock);
    chk("t5_busy3_in_wait", 64'(core_busy[3]), 64'd1);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("t5_ready",  64'(core_ready),  64'd0);
    chk("t5_busy",   64'(core_busy),   64'd0);
    chk("t5_mem_en", 64'(mem_en),      64'd0);
    chk("t5_err",    64'(err_illegal), 64'd0);
    chk("t5_rdata",  core_rdata,       64'd0);
    repeat (6) @(negedge Clock);

    // 6: cores 3 and 1 pending with rr_ptr=2 (set by serving core1 first)
    @(posedge Clock); #1;
    push_acc(1'b1, 16'h0060, 16'h7777);
    push_rdy(2'd1, 1'b0, 16'h0000);
    req(1, MC_WRITE, 16'h0060, 16'h7777);
    t0 = cyc;
    wait_ready(1, t0, 3, "t6_setup");
    req(1, MC_IDLE, 16'h0000, 16'h0000);
    @(posedge Clock); #1;
    push_acc(1'b0, 16'h0060, 16'h0000);
    push_acc(1'b0, 16'h0061, 16'h0000);
    push_rdy(2'd3, 1'b1, 16'h7777);
    push_rdy(2'd1, 1'b1, init_val(8'h61));
    req(3, MC_READ, 16'h0060, 16'h0000);
    req(1, MC_READ, 16'h0061, 16'h0000);
    t0 = cyc;
    wait_ready(3, t0, 4, "t6_core3_first");
    req(3, MC_IDLE, 16'h0000, 16'h0000);
    wait_ready(1, t0, 8, "t6_core1_wrap");
    req(1, MC_IDLE, 16'h0000, 16'h0000);
    @(posedge Clock); #1;
    push_acc(1'b1, 16'h0063, 16'h2A2A);
    push_acc(1'b1, 16'h0062, 16'h0A0A);
    push_rdy(2'd2, 1'b0, 16'h0000);
    push_rdy(2'd0, 1'b0, 16'h0000);
    req(0, MC_WRITE, 16'h0062, 16'h0A0A);
    req(2, MC_WRITE, 16'h0063, 16'h2A2A);
    t0 = cyc;
    wait_ready(2, t0, 3, "t6_ptr2_core2");
    req(2, MC_IDLE, 16'h0000, 16'h0000);
    wait_ready(0, t0, 6, "t6_ptr2_core0");
    req(0, MC_IDLE, 16'h0000, 16'h0000);

    repeat (4) @(negedge Clock);
    chk("acc_q_drained", 64'(acc_q.size()), 64'd0);
    chk("rdy_q_drained", 64'(rdy_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
